// File: rtl/decoder_pkg.sv
// Shared decoder definitions: FSM state encoding and a one-hot helper.
// Latency: none, declarations only.
// Backpressure: not applicable.
package decoder_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_LINES = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } dec_state_t;

    // Callers keep the low 2**SEL_W bits of the result.
    function automatic logic [MAX_LINES-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_LINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: tick marks the last of DWELL consecutive run cycles.
// Latency: tick is combinational from the count; the count restarts on the tick edge.
// Backpressure: none; clr takes priority over run.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/onehot_decoder_scan.sv
// Registered one-hot decoder with direct-select and timed auto-scan modes.
// Latency: one cycle from en/mode/sel_vld to y, y_vld, cur_idx and wrap.
// Backpressure: none; sel is consumed on every sel_vld strobe, en=0 wins over everything.
module onehot_decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_vld,
    output logic [(1<<SEL_W)-1:0] y,
    output logic                  y_vld,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  wrap
);

    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0]     Y_IDLE  = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    dec_state_t           state, nxt_state;
    logic [SEL_W-1:0]     nxt_idx;
    logic                 nxt_vld, nxt_wrap;
    logic [N-1:0]         nxt_y;
    logic [MAX_LINES-1:0] dec_full;
    logic                 run, tick;
    logic                 unused_dec;

    // Only an undisturbed scan cycle lets the dwell timer advance.
    assign run = en && mode && !sel_vld && (state == ST_SCAN);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!run),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        nxt_state = state;
        nxt_idx   = cur_idx;
        nxt_vld   = 1'b0;
        nxt_wrap  = 1'b0;
        if (!en) begin
            nxt_state = ST_IDLE;
        end else begin
            nxt_vld   = 1'b1;
            nxt_state = mode ? ST_SCAN : ST_DIRECT;
            if (sel_vld) begin
                nxt_idx = sel;
            end else if (tick) begin
                nxt_idx  = cur_idx + SEL_W'(1);
                nxt_wrap = (cur_idx == IDX_MAX);
            end
        end
    end

    always_comb begin
        dec_full = onehot(MAX_SEL_W'(nxt_idx));
        nxt_y    = nxt_vld ? (dec_full[N-1:0] ^ Y_IDLE) : Y_IDLE;
    end

    assign unused_dec = &{1'b0, dec_full};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cur_idx <= '0;
            y       <= Y_IDLE;
            y_vld   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= nxt_state;
            cur_idx <= nxt_idx;
            y       <= nxt_y;
            y_vld   <= nxt_vld;
            wrap    <= nxt_wrap;
        end
    end

endmodule

// File: doc/onehot_decoder_scan.md
ONEHOT_DECODER_SCAN -- requirements
Module: onehot_decoder_scan

Interface
REQ-001 Parameter SEL_W, default 2, select width; legal range 1..6.
REQ-002 Parameter DWELL, default 4, clock cycles each index is held in scan mode; legal range 1..255.
REQ-003 Parameter ACTIVE_LOW, default 0, output polarity of y; 1 inverts every bit of y.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port en, input, 1, block enable.
REQ-007 Port mode, input, 1, 0 = direct decode, 1 = auto-scan.
REQ-008 Port sel, input, SEL_W, binary index to decode or scan start point.
REQ-009 Port sel_vld, input, 1, one-cycle strobe qualifying sel.
REQ-010 Port y, output, 2**SEL_W, registered one-hot decode of cur_idx.
REQ-011 Port y_vld, output, 1, high when y carries a valid one-hot code.
REQ-012 Port cur_idx, output, SEL_W, registered index currently driven on y.
REQ-013 Port wrap, output, 1, one-cycle pulse when scan rolls from 2**SEL_W-1 to 0.

Function
REQ-014 FSM states IDLE, DIRECT, SCAN; all outputs registered, no combinational input-to-output path.
REQ-015 IDLE: y all-inactive, y_vld=0, wrap=0; cur_idx holds its last value.
REQ-016 IDLE with en=1, mode=0 -> DIRECT; with en=1, mode=1 -> SCAN; y_vld=1 on the cycle after the transition edge.
REQ-017 Entering from IDLE, cur_idx takes sel if sel_vld=1 that cycle, otherwise keeps its held value.
REQ-018 DIRECT: sel_vld=1 loads cur_idx=sel; y and cur_idx reflect the new index exactly 1 cycle after the sel_vld edge; without sel_vld, y holds.
REQ-019 SCAN: dwell counter counts 0..DWELL-1; at DWELL-1, cur_idx increments by 1 modulo 2**SEL_W and the counter returns to 0.
REQ-020 wrap=1 for exactly the one cycle in which cur_idx first shows 0 after 2**SEL_W-1; never asserted in DIRECT or IDLE.
REQ-021 DWELL=1: index advances every cycle; SEL_W=1: index toggles 0/1 with wrap on every return to 0.
REQ-022 SCAN with sel_vld=1: cur_idx=sel next cycle, dwell counter cleared, no wrap pulse (jump, not roll-over).
REQ-023 mode change while en=1 switches state on the next edge; DIRECT->SCAN continues from current cur_idx with counter cleared; SCAN->DIRECT freezes current cur_idx.
REQ-024 en=0 in any state -> IDLE on the next edge, overriding sel_vld and mode on the same cycle; counter cleared.
REQ-025 When y_vld=1, y has exactly one active bit at position cur_idx; when y_vld=0, no bit is active.
REQ-026 ACTIVE_LOW affects y only; y_vld, wrap, cur_idx are always active-high.

Reset
REQ-027 rst_n=0 asynchronously forces state IDLE, cur_idx=0, counter=0, y all-inactive (all 0, or all 1 if ACTIVE_LOW), y_vld=0, wrap=0.
REQ-028 Reset deassertion mid-scan restarts cleanly: first active state entered only via REQ-016.

Structure
REQ-029 Package decoder_pkg holds the FSM state encoding constants and an onehot(idx) function shared with future decoder blocks.
REQ-030 One sub-module, dwell_counter (parameter DWELL, ports clk, rst_n, clr, run, tick), generates the scan advance tick.
REQ-031 Implementation 120-400 lines RTL; no latches; widths derived from SEL_W only.

Verification
REQ-032 SEL_W=2: reset, en=1 mode=0, sel=2 sel_vld=1 -> next cycle y=4'b0100, cur_idx=2, y_vld=1.
REQ-033 SEL_W=2, DWELL=4, scan from sel=3 -> y=1000 for 4 cycles, then y=0001 with wrap=1 for one cycle, then 0010 after 4 more.
REQ-034 SCAN at cur_idx=1, sel=3 sel_vld=1 -> next cycle cur_idx=3, counter 0, wrap=0; next advance after exactly DWELL cycles.
REQ-035 en=0 and sel_vld=1 same cycle -> next cycle y=0, y_vld=0, cur_idx unchanged.
REQ-036 ACTIVE_LOW=1, SEL_W=3, DIRECT sel=5 -> y=8'b11011111; rst_n pulsed low asynchronously mid-scan -> y=8'hFF, y_vld=0 immediately.
REQ-037 Assertion on every cycle: y_vld implies onehot(y^polarity), !y_vld implies y inactive, wrap implies cur_idx=0 in SCAN.
